// File: rtl/one_hot_check.sv
// Registered one-hot validity monitor for an N-bit grant/select/state vector.
// Flags one-hot, all-zero or multi-bit patterns and reports the set-bit index, one cycle later.
module one_hot_check #(
    parameter  int N     = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     sig_in,
    input  logic             en,
    output logic             one_hot,
    output logic             zero,
    output logic             multi,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic             zero_c;
    logic             single_c;
    logic [IDX_W-1:0] idx_c;

    assign zero_c   = (sig_in == '0);
    assign single_c = !zero_c && ((sig_in & (sig_in - N'(1))) == '0);

    // Encoder result is only meaningful when single_c; it is masked at the flop.
    always_comb begin
        idx_c = '0;
        for (int i = 0; i < N; i++) begin
            if (sig_in[i]) begin
                idx_c = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            one_hot <= 1'b0;
            zero    <= 1'b0;
            multi   <= 1'b0;
            idx     <= '0;
            valid   <= 1'b0;
        end else begin
            valid   <= en;
            one_hot <= en && single_c;
            zero    <= en && zero_c;
            multi   <= en && !zero_c && !single_c;
            idx     <= (en && single_c) ? idx_c : '0;
        end
    end

endmodule

// File: tb/tb_one_hot_check.sv
// Bench for one_hot_check: N = 8, 5 and 1 instances driven side by side,
// compared every cycle against a popcount-based reference model.
module tb_one_hot_check;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] sig8;
    logic [4:0] sig5;
    logic [0:0] sig1;

    logic       oh8, z8, m8, v8;
    logic [2:0] ix8;
    logic       oh5, z5, m5, v5;
    logic [2:0] ix5;
    logic       oh1, z1, m1, v1;
    logic [0:0] ix1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    one_hot_check #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .sig_in(sig8), .en(en),
        .one_hot(oh8), .zero(z8), .multi(m8), .idx(ix8), .valid(v8)
    );

    one_hot_check #(.N(5)) dut5 (
        .clk(clk), .rst(rst), .sig_in(sig5), .en(en),
        .one_hot(oh5), .zero(z5), .multi(m5), .idx(ix5), .valid(v5)
    );

    one_hot_check #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .sig_in(sig1), .en(en),
        .one_hot(oh1), .zero(z1), .multi(m1), .idx(ix1), .valid(v1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: classify by population count, index by log2 of the value.
    task automatic model(input int n, input int v_in, input bit r, input bit e,
                         output int oh, output int z, output int m, output int ix, output int vl);
        int v;
        int cnt;
        v   = v_in & ((1 << n) - 1);
        cnt = $countones(v);
        oh = 0; z = 0; m = 0; ix = 0; vl = 0;
        if (!r && e) begin
            vl = 1;
            oh = (cnt == 1) ? 1 : 0;
            z  = (cnt == 0) ? 1 : 0;
            m  = (cnt > 1)  ? 1 : 0;
            ix = (cnt == 1) ? $clog2(v) : 0;
        end
    endtask

    task automatic check_dut(input string name, input int n, input int v, input bit r, input bit e,
                             input logic o_oh, input logic o_z, input logic o_m,
                             input logic [2:0] o_ix, input logic o_v);
        int oh, z, m, ix, vl;
        model(n, v, r, e, oh, z, m, ix, vl);
        check($sformatf("%s one_hot v=%0h e=%0d r=%0d", name, v, e, r), 32'(o_oh), 32'(oh));
        check($sformatf("%s zero v=%0h e=%0d r=%0d", name, v, e, r), 32'(o_z), 32'(z));
        check($sformatf("%s multi v=%0h e=%0d r=%0d", name, v, e, r), 32'(o_m), 32'(m));
        check($sformatf("%s idx v=%0h e=%0d r=%0d", name, v, e, r), 32'(o_ix), 32'(ix));
        check($sformatf("%s valid v=%0h e=%0d r=%0d", name, v, e, r), 32'(o_v), 32'(vl));
    endtask

    // Drive on the falling edge, sample just after the next rising edge.
    task automatic step(input bit r, input bit e, input int s8, input int s5, input int s1);
        @(negedge clk);
        rst  = r;
        en   = e;
        sig8 = 8'(s8);
        sig5 = 5'(s5);
        sig1 = 1'(s1);
        @(posedge clk);
        #1;
        check_dut("n8", 8, s8, r, e, oh8, z8, m8, ix8, v8);
        check_dut("n5", 5, s5, r, e, oh5, z5, m5, ix5, v5);
        check_dut("n1", 1, s1, r, e, oh1, z1, m1, 3'(ix1), v1);
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        sig8 = 8'h01;
        sig5 = 5'h01;
        sig1 = 1'b1;

        // Reset held with a live one-hot input, then released.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h01, 5'h01, 1);
        step(1'b0, 1'b1, 8'h01, 5'h01, 1);

        // Exhaustive N=8 with en high; smaller widths see the truncated value.
        for (int v = 0; v < 256; v++) step(1'b0, 1'b1, v, v, v);

        // Enable gating.
        step(1'b0, 1'b0, 8'b0000_0100, 5'b00100, 1);
        step(1'b0, 1'b0, 8'h00, 5'h00, 0);
        step(1'b0, 1'b0, 8'hFF, 5'h1F, 1);

        // Boundaries.
        step(1'b0, 1'b1, 8'h80, 5'h10, 1);
        step(1'b0, 1'b1, 8'h01, 5'h01, 1);
        step(1'b0, 1'b1, 8'hC0, 5'h18, 0);
        step(1'b0, 1'b1, 8'hFF, 5'h1F, 1);

        // Mid-stream reset pulse within a one-hot stream.
        for (int i = 0; i < 8; i++) begin
            step(i == 4, 1'b1, 1 << i, 1 << (i % 5), 1);
        end

        // Parameter sweep with en in {0,1} for the narrow instances.
        for (int e = 0; e < 2; e++) begin
            for (int v = 0; v < 32; v++) step(1'b0, e[0], v * 8, v, v & 1);
        end

        // Random traffic, biased toward one-hot patterns, with occasional reset.
        for (int i = 0; i < 400; i++) begin
            int s8r, s5r;
            bit rr, er;
            rr  = ($urandom_range(0, 19) == 0);
            er  = ($urandom_range(0, 3) != 0);
            s8r = ($urandom_range(0, 1) == 1) ? (1 << $urandom_range(0, 7)) : int'($urandom_range(0, 255));
            s5r = ($urandom_range(0, 1) == 1) ? (1 << $urandom_range(0, 4)) : int'($urandom_range(0, 31));
            step(rr, er, s8r, s5r, int'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
